// File: rtl/calc_sequencer.sv
// Operand-entry sequencer for a small calculator: captures A then B/OP,
// runs a one-cycle add or an N-cycle shift-add multiply, and registers the result.
module calc_sequencer #(
    parameter int N = 4
) (
    input  logic           CLK,
    input  logic           CLR,
    input  logic [N-1:0]   DIN,
    input  logic           ENTER,
    input  logic           OP,
    output logic           LD_A,
    output logic           LD_B,
    output logic           LD_R,
    output logic [2*N-1:0] RESULT,
    output logic           BUSY,
    output logic           DONE
);
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {S_IDLE, S_GET_B, S_EXEC, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    a_q, b_q, b_sh;
    logic            op_q;
    logic [2*N-1:0]  acc_q, acc_nxt, a_ext, b_ext;
    logic [CW-1:0]   cnt_q;
    logic            last, ld_a, ld_b, ld_r;

    assign a_ext = {{N{1'b0}}, a_q};
    assign b_ext = {{N{1'b0}}, b_q};
    assign b_sh  = b_q >> cnt_q;
    // ADD finishes in one cycle; MUL stops after bit N-1 so the counter never wraps
    assign last  = !op_q || (cnt_q == CW'(N - 1));

    always_comb begin
        if (op_q)
            acc_nxt = acc_q + (b_sh[0] ? (a_ext << cnt_q) : '0);
        else
            acc_nxt = a_ext + b_ext;
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ld_a    = 1'b0;
        ld_b    = 1'b0;
        ld_r    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (ENTER) begin
                    ld_a    = 1'b1;
                    state_d = S_GET_B;
                end
            end
            S_GET_B: begin
                if (ENTER) begin
                    ld_b    = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (last) begin
                    ld_r    = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are gated by CLR so they stay quiet while reset is held
    assign LD_A = ld_a & CLR;
    assign LD_B = ld_b & CLR;
    assign LD_R = ld_r & CLR;
    assign BUSY = (state_q == S_EXEC) & CLR;
    assign DONE = (state_q == S_DONE) & CLR;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= 1'b0;
            acc_q  <= '0;
            cnt_q  <= '0;
            RESULT <= '0;
        end else begin
            if (ld_a) a_q <= DIN;
            if (ld_b) begin
                b_q   <= DIN;
                op_q  <= OP;
                acc_q <= '0;
                cnt_q <= '0;
            end
            if (state_q == S_EXEC) begin
                acc_q <= acc_nxt;
                if (!last) cnt_q <= cnt_q + CW'(1);
            end
            if (ld_r) RESULT <= acc_nxt;
        end
    end
endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer (N=4): directed scenarios plus random
// operations compared against an arithmetic reference model.
module tb_calc_sequencer;
    localparam int N = 4;

    logic           CLK = 1'b0;
    logic           CLR = 1'b0;
    logic [N-1:0]   DIN = '0;
    logic           ENTER = 1'b0;
    logic           OP = 1'b0;
    logic           LD_A, LD_B, LD_R, BUSY, DONE;
    logic [2*N-1:0] RESULT;

    int checks = 0;
    int failures = 0;
    int last_result = 0;

    calc_sequencer #(.N(N)) dut (
        .CLK(CLK), .CLR(CLR), .DIN(DIN), .ENTER(ENTER), .OP(OP),
        .LD_A(LD_A), .LD_B(LD_B), .LD_R(LD_R), .RESULT(RESULT),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full operation; the model is plain arithmetic on the operands.
    task automatic run_op(input int a, input int b, input bit op, input bit junk);
        int exp_r, busy_n, ldr_n, cyc;
        exp_r  = op ? a * b : a + b;
        busy_n = 0;
        ldr_n  = 0;
        cyc    = 0;
        @(negedge CLK);
        DIN = N'(a); ENTER = 1'b1; OP = 1'($urandom);
        #1;
        chk("ld_a_on_enter", 32'(LD_A), 1);
        chk("ld_b_quiet_a", 32'(LD_B), 0);
        chk("result_hold_a", 32'(RESULT), last_result);
        @(negedge CLK);
        DIN = N'(b); OP = op; ENTER = 1'b1;
        #1;
        chk("ld_b_on_enter", 32'(LD_B), 1);
        chk("ld_a_quiet_b", 32'(LD_A), 0);
        @(negedge CLK);
        ENTER = 1'b0;
        while (BUSY && cyc < 20) begin
            busy_n++;
            if (LD_R) ldr_n++;
            chk("result_hold_exec", 32'(RESULT), last_result);
            if (junk) begin
                DIN = N'($urandom); OP = 1'($urandom); ENTER = 1'($urandom);
            end
            #1;
            if (LD_A || LD_B) chk("no_strobe_exec", {30'd0, LD_A, LD_B}, 0);
            @(negedge CLK);
            cyc++;
        end
        ENTER = 1'b0;
        chk("busy_cycles", busy_n, op ? N : 1);
        chk("ld_r_pulses", ldr_n, 1);
        chk("done_flag", 32'(DONE), 1);
        chk("result", 32'(RESULT), exp_r);
        last_result = exp_r;
    endtask

    initial begin
        ENTER = 1'b1;
        #12;
        chk("rst_ld_a", 32'(LD_A), 0);
        chk("rst_outs", {27'd0, LD_B, LD_R, BUSY, DONE, 1'b0}, 0);
        chk("rst_result", 32'(RESULT), 0);
        @(negedge CLK);
        ENTER = 1'b0;
        CLR = 1'b1;

        run_op(3, 5, 1'b0, 1'b0);
        run_op(15, 15, 1'b1, 1'b0);
        run_op(15, 15, 1'b0, 1'b0);
        run_op(7, 6, 1'b1, 1'b1);
        run_op(3, 4, 1'b1, 1'b0);
        run_op(9, 2, 1'b0, 1'b0);

        // Reset in the second multiply cycle, between edges
        @(negedge CLK); DIN = 4'd15; ENTER = 1'b1;
        @(negedge CLK); DIN = 4'd15; OP = 1'b1;
        @(negedge CLK); ENTER = 1'b0;
        @(posedge CLK); #2;
        CLR = 1'b0; ENTER = 1'b1;
        #1;
        chk("mid_rst_outs", {27'd0, LD_A, LD_B, LD_R, BUSY, DONE}, 0);
        chk("mid_rst_result", 32'(RESULT), 0);
        @(posedge CLK); @(posedge CLK); #1;
        chk("mid_rst_hold", 32'(RESULT), 0);
        chk("mid_rst_ldr", 32'(LD_R), 0);
        @(negedge CLK);
        ENTER = 1'b0; CLR = 1'b1;
        last_result = 0;
        run_op(2, 3, 1'b1, 1'b0);

        for (int i = 0; i < 30; i++)
            run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   1'($urandom), 1'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the operand width in bits (N >= 2).
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port CLR, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port DIN, input, N bits: operand data entry.
REQ-005 The block SHALL have port ENTER, input, 1 bit: synchronous one-cycle strobe that accepts DIN.
REQ-006 The block SHALL have port OP, input, 1 bit: function select, 0 = ADD, 1 = MUL; sampled with operand B.
REQ-007 The block SHALL have port LD_A, output, 1 bit: clock-enable strobe for the external operand-A register.
REQ-008 The block SHALL have port LD_B, output, 1 bit: clock-enable strobe for the external operand-B register.
REQ-009 The block SHALL have port LD_R, output, 1 bit: clock-enable strobe for the external result register.
REQ-010 The block SHALL have port RESULT, output, 2N bits: registered, unsigned result.
REQ-011 The block SHALL have port BUSY, output, 1 bit: high while in EXEC.
REQ-012 The block SHALL have port DONE, output, 1 bit: high while in state DONE.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, GET_B, EXEC and DONE.
REQ-014 In IDLE with ENTER=1, the block SHALL capture DIN into internal A, assert LD_A combinationally that cycle, and go to GET_B.
REQ-015 In GET_B with ENTER=1, the block SHALL capture DIN into internal B and OP into internal op, assert LD_B that cycle, clear the accumulator and counter, and go to EXEC.
REQ-016 In EXEC, ADD SHALL take exactly 1 cycle: the accumulator is loaded with the zero-extended sum A+B (N+1 significant bits).
REQ-017 In EXEC, MUL SHALL take exactly N cycles of unsigned shift-add: in cycle i (0..N-1), if B[i]=1, add A shifted left by i into the accumulator.
REQ-018 The iteration counter SHALL be ceil(log2(N))+1 bits and SHALL NOT wrap within one operation.
REQ-019 On the last EXEC cycle, the block SHALL assert LD_R, write the final value to RESULT on that edge, and go to DONE.
REQ-020 In DONE, RESULT SHALL hold, DONE SHALL be 1, and ENTER=1 SHALL act as the IDLE transition (capture A, assert LD_A, go to GET_B).
REQ-021 ENTER during EXEC SHALL be ignored: no capture and no strobe.
REQ-022 DIN and OP changes outside the capture cycles SHALL NOT affect an operation in progress.
REQ-023 RESULT SHALL change only on an LD_R edge or on reset; a new operation SHALL NOT clear it before its completion.
REQ-024 MUL of two maximum operands SHALL fit in 2N bits without overflow, and ADD SHALL never overflow 2N bits.
REQ-025 LD_A, LD_B and LD_R SHALL be mutually exclusive and each at most one cycle wide per operation.

Reset
REQ-026 CLR=0 SHALL immediately force the state to IDLE, and A, B, op, the accumulator, the counter and RESULT to 0, regardless of CLK.
REQ-027 While CLR=0, LD_A, LD_B, LD_R, BUSY and DONE SHALL be 0.
REQ-028 Reset asserted mid-EXEC SHALL abort the operation: no LD_R is issued and RESULT is 0.
REQ-029 After CLR rises, the first rising CLK edge with ENTER=1 SHALL be accepted as operand A.

Verification (N=4)
REQ-030 The bench SHALL apply ENTER with DIN=3, then ENTER with DIN=5 and OP=0, and require BUSY=1 for 1 cycle, LD_R pulsed once, RESULT=8 and DONE=1.
REQ-031 The bench SHALL apply A=15, B=15, OP=1, and require BUSY=1 for exactly 4 cycles and then RESULT=225 (8'hE1) with DONE=1.
REQ-032 The bench SHALL apply A=15, B=15, OP=0, and require RESULT=30.
REQ-033 The bench SHALL apply A=7, B=6, OP=1 while pulsing ENTER, toggling DIN and toggling OP during EXEC, and require RESULT=42 with no extra LD_A or LD_B.
REQ-034 The bench SHALL assert CLR=0 in the 2nd MUL cycle between clock edges, and require all outputs to be 0 at once, RESULT to remain 0, and the next ENTER to assert LD_A.
REQ-035 The bench SHALL run 3*4=12 and then, from DONE, 9+2, and require RESULT to hold 12 through GET_B and EXEC and to become 11 only on the LD_R edge.
